// File: rtl/power_pkg.sv
// Shared types and constants for the Q10.10 integer-power unit.
package power_pkg;

    localparam int DATA_W    = 20;
    localparam int FRAC_BITS = 10;

    localparam logic [DATA_W-1:0] Q_ONE = 20'h00400;
    localparam logic [DATA_W-1:0] Q_MAX = 20'hFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STORE   = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_OUTPUT  = 2'd3
    } state_t;

endpackage

// File: rtl/q10_mul_sat.sv
// Combinational fixed-point multiply: truncates the product to the operand
// format and saturates to all-ones on overflow or when overflow is already sticky.
module q10_mul_sat
    import power_pkg::*;
#(
    parameter int W  = DATA_W,
    parameter int FB = FRAC_BITS
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ovf_in,
    output logic [W-1:0] r,
    output logic         ovf_out
);

    logic [2*W-1:0] prod;
    logic           high_bits;

    always_comb begin
        prod      = a * b;
        // anything above the retained window means the truncated result does not fit
        high_bits = |prod[2*W-1:W+FB];
        if (ovf_in || high_bits) begin
            r       = {W{1'b1}};
            ovf_out = 1'b1;
        end else begin
            r       = prod[W+FB-1:FB];
            ovf_out = 1'b0;
        end
    end

endmodule

// File: rtl/power_q10.sv
// Iterative x^n for unsigned Q10.10 x and 3-bit n: one truncating, saturating
// multiply per cycle, sequenced by a small FSM with registered outputs.
//
// state      | meaning
// ST_IDLE    | waiting for in_valid
// ST_STORE   | capturing operands while in_valid holds; preload acc/cnt
// ST_COMPUTE | one multiply per cycle until the exponent count is spent
// ST_OUTPUT  | present acc/ovf to the output registers for one cycle
module power_q10 #(
    parameter int DATA_W    = power_pkg::DATA_W,
    parameter int FRAC_BITS = power_pkg::FRAC_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic [2:0]        in_data_2,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf
);

    import power_pkg::*;

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1) << FRAC_BITS;

    state_t            state, state_nx;
    logic [DATA_W-1:0] x_q;
    logic [2:0]        n_q;
    logic [DATA_W-1:0] acc;
    logic [2:0]        cnt;
    logic              ovf;

    logic [DATA_W-1:0] mul_r;
    logic              mul_ovf;

    logic              valid_nx;
    logic [DATA_W-1:0] data_nx;
    logic              ovf_nx;

    q10_mul_sat #(
        .W  (DATA_W),
        .FB (FRAC_BITS)
    ) u_mul (
        .a       (acc),
        .b       (x_q),
        .ovf_in  (ovf),
        .r       (mul_r),
        .ovf_out (mul_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (in_valid) state_nx = ST_STORE;
            ST_STORE:   if (!in_valid) state_nx = ST_COMPUTE;
            // cnt<=1 leaves after the final multiply; n=0 still spends one cycle here
            ST_COMPUTE: if (cnt <= 3'd1) state_nx = ST_OUTPUT;
            ST_OUTPUT:  state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        valid_nx = (state == ST_OUTPUT);
        data_nx  = '0;
        ovf_nx   = 1'b0;
        if (valid_nx) begin
            data_nx = acc;
            ovf_nx  = ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            n_q <= '0;
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            // operands captured on every valid cycle, so the last one wins
            if (in_valid && (state == ST_IDLE || state == ST_STORE)) begin
                x_q <= in_data_1;
                n_q <= in_data_2;
            end
            case (state)
                ST_STORE: begin
                    acc <= ONE;
                    cnt <= n_q;
                    ovf <= 1'b0;
                end
                ST_COMPUTE: begin
                    if (cnt != 3'd0) begin
                        acc <= mul_r;
                        ovf <= mul_ovf;
                        cnt <= cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            out_valid <= valid_nx;
            out_data  <= data_nx;
            out_ovf   <= ovf_nx;
        end
    end

endmodule

// File: tb/tb_power_q10.sv
// Directed and randomized checks of power_q10 against an arithmetic x^n model.
module tb_power_q10;
    import power_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [19:0] in_data_1;
    logic [2:0]  in_data_2;
    logic        out_valid;
    logic [19:0] out_data;
    logic        out_ovf;

    int checks   = 0;
    int failures = 0;

    power_q10 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data_1 (in_data_1),
        .in_data_2 (in_data_2),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // x^n by repeated truncating multiplication, saturating once any step exceeds 20 bits
    task automatic ref_pow(input logic [19:0] x, input logic [2:0] n,
                           output logic [19:0] r, output logic ovf);
        longint a;
        a   = 1024;
        ovf = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            if (!ovf) begin
                a = (a * longint'(x)) / 1024;
                if (a >= 64'd1048576) ovf = 1'b1;
            end
        end
        r = ovf ? 20'hFFFFF : 20'(a);
    endtask

    task automatic drive_cycle(input logic [19:0] x, input logic [2:0] n);
        in_valid  = 1'b1;
        in_data_1 = x;
        in_data_2 = n;
        @(posedge clk); #1;
    endtask

    // called right after the posedge that closes the last in_valid cycle T
    task automatic finish_txn(input logic [19:0] x, input logic [2:0] n,
                              input bit pulse, input string tag);
        logic [19:0] exp_r;
        logic        exp_ovf;
        int          lat;
        int          cyc;
        bit          got;
        ref_pow(x, n, exp_r, exp_ovf);
        lat = 3 + ((n == 3'd0) ? 1 : int'(n));
        cyc = 1;
        got = 1'b0;
        while (cyc < 20) begin
            if (pulse && cyc >= 2 && cyc <= lat - 1) begin
                in_valid  = 1'($urandom_range(0, 1));
                in_data_1 = 20'($urandom);
                in_data_2 = 3'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        check({tag, "_valid_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
        check({tag, "_data"}, 32'(out_data), 32'(exp_r));
        check({tag, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
        @(posedge clk); #1;
        check({tag, "_valid_one_cycle"}, 32'(out_valid), 32'd0);
        check({tag, "_data_idle_zero"}, {11'd0, out_ovf, out_data}, 32'd0);
    endtask

    task automatic one_shot(input logic [19:0] x, input logic [2:0] n, input string tag);
        drive_cycle(x, n);
        finish_txn(x, n, 1'b0, tag);
    endtask

    initial begin
        logic [19:0] rx;
        logic [2:0]  rn;
        int          hold;
        bit          seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data_1 = '0;
        in_data_2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_data", 32'(out_data), 32'd0);
        check("reset_ovf", 32'(out_ovf), 32'd0);
        check("reset_state", 32'(dut.state), 32'(ST_IDLE));
        rst = 1'b0;
        @(posedge clk); #1;

        one_shot(20'h00800, 3'd3, "two_cubed");
        one_shot(20'h12345, 3'd0, "n_zero");
        one_shot(20'h00000, 3'd0, "zero_pow_zero");
        one_shot(20'h00000, 3'd5, "zero_base");
        one_shot(20'h00600, 3'd2, "one_five_sq");
        one_shot(20'h00401, 3'd2, "trunc_sq");
        one_shot(20'h08000, 3'd3, "overflow");
        one_shot(20'h00200, 3'd7, "half_pow7");
        one_shot(20'hFFFFF, 3'd1, "max_pow1");

        // operand changes while valid is held; ignored pulses during compute
        drive_cycle(20'h00400, 3'd2);
        drive_cycle(20'h00C00, 3'd2);
        drive_cycle(20'h00800, 3'd2);
        finish_txn(20'h00800, 3'd2, 1'b1, "last_wins");
        check("last_wins_value", 32'(out_data), 32'd0);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("no_extra_valid", 32'(seen), 32'd0);

        // abort mid-compute
        drive_cycle(20'h00800, 3'd7);
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_data", 32'(out_data), 32'd0);
        check("abort_state", 32'(dut.state), 32'(ST_IDLE));
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        one_shot(20'h00C00, 3'd2, "after_abort");

        for (int t = 0; t < 40; t++) begin
            hold = $urandom_range(1, 3);
            rx   = '0;
            rn   = '0;
            for (int h = 0; h < hold; h++) begin
                rx = ($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'($urandom_range(0, 20'h00C00));
                rn = 3'($urandom);
                drive_cycle(rx, rn);
            end
            finish_txn(rx, rn, bit'($urandom_range(0, 1)), $sformatf("rand%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
